// File: rtl/param_fifo.sv
// -----------------------------------------------------------------------------
// param_fifo
//
// Single-clock synchronous FIFO with registered read data, occupancy count,
// threshold flags and sticky overflow/underflow error flags.
//
// Parameters
//   FIFO_WIDTH    : data word width in bits
//   FIFO_DEPTH    : number of entries (power of two, >= 2)
//   AFULL_THRESH  : almost_full asserts when count >= this (1..FIFO_DEPTH-1)
//   AEMPTY_THRESH : almost_empty asserts when count <= this (1..FIFO_DEPTH-1)
//
// Ports
//   clk          : sole clock, rising edge
//   rstN         : asynchronous active-low reset
//   wr_en        : write request, data_in captured when accepted
//   data_in      : write data
//   rd_en        : read request, data_out updated when accepted
//   err_clr      : clears overflow/underflow (a coincident set wins)
//   data_out     : registered read data, holds between accepted reads
//   empty, full  : occupancy flags decoded from count
//   almost_empty, almost_full : threshold flags decoded from count
//   count        : current occupancy, 0..FIFO_DEPTH
//   overflow     : sticky, set by a write request while full
//   underflow    : sticky, set by a read request while empty
// -----------------------------------------------------------------------------
module param_fifo #(
    parameter int FIFO_WIDTH    = 32,
    parameter int FIFO_DEPTH    = 32,
    parameter int AFULL_THRESH  = FIFO_DEPTH - 4,
    parameter int AEMPTY_THRESH = 4
) (
    input  logic                          clk,
    input  logic                          rstN,
    input  logic                          wr_en,
    input  logic [FIFO_WIDTH-1:0]         data_in,
    input  logic                          rd_en,
    input  logic                          err_clr,
    output logic [FIFO_WIDTH-1:0]         data_out,
    output logic                          empty,
    output logic                          full,
    output logic                          almost_empty,
    output logic                          almost_full,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_THRESH);
    localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_THRESH);

    // Reject illegal parameterisations while elaborating.
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("param_fifo: FIFO_DEPTH must be a power of two and at least 2");
    end
    if (FIFO_WIDTH < 1) begin : g_bad_width
        $error("param_fifo: FIFO_WIDTH must be at least 1");
    end
    if (AFULL_THRESH < 1 || AFULL_THRESH > FIFO_DEPTH - 1) begin : g_bad_afull
        $error("param_fifo: AFULL_THRESH must be in 1..FIFO_DEPTH-1");
    end
    if (AEMPTY_THRESH < 1 || AEMPTY_THRESH > FIFO_DEPTH - 1) begin : g_bad_aempty
        $error("param_fifo: AEMPTY_THRESH must be in 1..FIFO_DEPTH-1");
    end

    logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count_q;
    logic                  wr_acc;
    logic                  rd_acc;

    // Request semantics: wr_en/rd_en are requests sampled at the rising edge.
    // A write is taken only when the FIFO is not full, a read only when it is
    // not empty, both judged on the pre-edge count. A refused request leaves
    // memory, pointers, count and data_out untouched and only raises the
    // matching sticky error flag. Because acceptance depends on pre-edge
    // state, a full FIFO with both requests drains one word and refuses the
    // write, and an empty FIFO with both requests stores one word and
    // refuses the read.
    assign wr_acc = wr_en && !full;
    assign rd_acc = rd_en && !empty;

    // Storage is not reset; a word is only ever read after being written.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // Pointers are exactly AW bits, so the +1 wraps DEPTH-1 -> 0 naturally.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_q  <= '0;
            data_out <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_acc) begin
                rd_ptr   <= rd_ptr + AW'(1);
                data_out <= mem[rd_ptr];
            end
            case ({wr_acc, rd_acc})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Sticky errors: set has priority over err_clr on the same edge.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en && full) begin
                overflow <= 1'b1;
            end else if (err_clr) begin
                overflow <= 1'b0;
            end
            if (rd_en && empty) begin
                underflow <= 1'b1;
            end else if (err_clr) begin
                underflow <= 1'b0;
            end
        end
    end

    // All status flags are pure decodes of the registered count, so they
    // move on the same edge as count and take reset values with it.
    assign count        = count_q;
    assign empty        = (count_q == '0);
    assign full         = (count_q == DEPTH_C);
    assign almost_full  = (count_q >= AFULL_C);
    assign almost_empty = (count_q <= AEMPTY_C);

endmodule
